// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, instruction field positions and the
// ID/EX payload that decode hands to execute.
package decode_pkg;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int CW    = 16;
    localparam int NREGS = 1 << AW;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RS1_HI  = 8;
    localparam int RS1_LO  = 6;
    localparam int RS2_HI  = 5;
    localparam int RS2_LO  = 3;
    localparam int IMM6_W  = 6;
    localparam int IMM9_W  = 9;

    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] opA;
        logic [DW-1:0] opB;
        logic [AW-1:0] rd;
        logic          we;
        logic          illegal;
    } idex_t;

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register busy vector tracking outstanding writes; a register retiring
// this cycle already reads as free to the hazard queries.
module decode_scoreboard
    import decode_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_addr_i,
    input  logic          clr_en_i,
    input  logic [AW-1:0] clr_addr_i,
    input  logic [AW-1:0] qa_addr_i,
    input  logic [AW-1:0] qb_addr_i,
    input  logic [AW-1:0] qd_addr_i,
    output logic          qa_busy_o,
    output logic          qb_busy_o,
    output logic          qd_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_eff;

    always_comb begin
        busy_eff = busy_q;
        if (clr_en_i) busy_eff[clr_addr_i] = 1'b0;
        // Set is applied after clear so a same-index collision stays busy.
        busy_d = busy_eff;
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
    end

    assign qa_busy_o = busy_eff[qa_addr_i];
    assign qb_busy_o = busy_eff[qb_addr_i];
    assign qd_busy_o = busy_eff[qd_addr_i];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: operand resolution with writeback bypass, scoreboard
// hazard stalls, and a one-entry ID/EX register toward execute.
module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH  = DW,
    parameter int ADDR_W = AW,
    parameter int CNT_W  = CW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [WIDTH-1:0]  if_instr,
    output logic              if_ready,
    output logic [ADDR_W-1:0] rf_ra,
    output logic [ADDR_W-1:0] rf_rb,
    input  logic [WIDTH-1:0]  rf_a,
    input  logic [WIDTH-1:0]  rf_b,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [3:0]        ex_op,
    output logic [WIDTH-1:0]  ex_opA,
    output logic [WIDTH-1:0]  ex_opB,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_we,
    output logic              ex_illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [3:0]              op;
    logic [ADDR_W-1:0]       rd;
    logic signed [IMM6_W-1:0] imm6_s;
    logic signed [WIDTH-1:0] imm6_ext;
    logic [WIDTH-1:0]        imm9_ext;
    logic [WIDTH-1:0]        byp_a;
    logic [WIDTH-1:0]        byp_b;
    logic                    use_a, use_b, we, illegal;
    logic                    busy_a, busy_b, busy_d;
    logic                    hazard, slot_free, accept;
    idex_t                   idex_q, idex_d;
    logic                    ex_valid_q;
    logic [CNT_W-1:0]        stall_cnt_q;

    assign op       = if_instr[OP_HI:OP_LO];
    assign rd       = if_instr[RD_HI:RD_LO];
    assign rf_ra    = if_instr[RS1_HI:RS1_LO];
    assign rf_rb    = if_instr[RS2_HI:RS2_LO];
    assign imm6_s   = if_instr[IMM6_W-1:0];
    assign imm6_ext = {{(WIDTH-IMM6_W){imm6_s[IMM6_W-1]}}, imm6_s};
    assign imm9_ext = {{(WIDTH-IMM9_W){1'b0}}, if_instr[IMM9_W-1:0]};

    // The register file writes on this same edge, so its read port is stale.
    assign byp_a = (wb_valid && wb_addr == rf_ra) ? wb_data : rf_a;
    assign byp_b = (wb_valid && wb_addr == rf_rb) ? wb_data : rf_b;

    always_comb begin
        use_a   = 1'b0;
        use_b   = 1'b0;
        we      = 1'b0;
        illegal = 1'b0;
        idex_d  = '0;
        idex_d.op = op;
        idex_d.rd = rd;
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                use_a = 1'b1;
                use_b = 1'b1;
                we    = 1'b1;
                idex_d.opA = byp_a;
                idex_d.opB = byp_b;
            end
            OP_ADDI: begin
                use_a = 1'b1;
                we    = 1'b1;
                idex_d.opA = byp_a;
                idex_d.opB = imm6_ext;
            end
            OP_LDI: begin
                we = 1'b1;
                idex_d.opB = imm9_ext;
            end
            default: illegal = 1'b1;
        endcase
        idex_d.we      = we;
        idex_d.illegal = illegal;
    end

    decode_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .set_en_i   (accept && we),
        .set_addr_i (rd),
        .clr_en_i   (wb_valid),
        .clr_addr_i (wb_addr),
        .qa_addr_i  (rf_ra),
        .qb_addr_i  (rf_rb),
        .qd_addr_i  (rd),
        .qa_busy_o  (busy_a),
        .qb_busy_o  (busy_b),
        .qd_busy_o  (busy_d)
    );

    assign hazard    = if_valid && ((use_a && busy_a) || (use_b && busy_b) || (we && busy_d));
    assign slot_free = !ex_valid_q || ex_ready;
    assign if_ready  = slot_free && !hazard;
    assign accept    = if_valid && if_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            idex_q     <= '0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            idex_q     <= idex_d;
        end else if (slot_free) begin
            ex_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (if_valid && slot_free && hazard && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_op      = idex_q.op;
    assign ex_opA     = idex_q.opA;
    assign ex_opB     = idex_q.opB;
    assign ex_rd      = idex_q.rd;
    assign ex_we      = idex_q.we;
    assign ex_illegal = idex_q.illegal;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, bypass, hazard stalls, back-pressure,
// illegal opcode and scoreboard set/clear collision.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic [2:0]  rf_ra, rf_rb;
    logic [15:0] rf_a, rf_b;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [15:0] ex_opA, ex_opB;
    logic [2:0]  ex_rd;
    logic        ex_we, ex_illegal;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_ready   (if_ready),
        .rf_ra      (rf_ra),
        .rf_rb      (rf_rb),
        .rf_a       (rf_a),
        .rf_b       (rf_b),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_ready   (ex_ready),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_opA     (ex_opA),
        .ex_opB     (ex_opB),
        .ex_rd      (ex_rd),
        .ex_we      (ex_we),
        .ex_illegal (ex_illegal),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch must hold if_instr while it is stalled.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_instr = '0;
    always @(posedge clk) begin
        if (reset && prev_stall)
            assert (if_instr == prev_instr) else $error("if_instr changed while stalled");
        prev_stall <= reset && if_valid && !if_ready;
        prev_instr <= if_instr;
    end

    initial begin
        reset    = 1'b0;
        if_valid = 1'b1;
        if_instr = 16'h64AB;
        rf_a     = '0;
        rf_b     = '0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        ex_ready = 1'b1;

        // Held in reset across one edge
        #12;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_op", ex_op, 0);
        chk("rst_ex_opA", ex_opA, 0);
        chk("rst_ex_opB", ex_opB, 0);
        chk("rst_ex_rd_we_ill", {ex_rd, ex_we, ex_illegal}, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_busy", dut.u_sb.busy_q, 0);
        reset = 1'b1;

        // LDI r2,0xAB accepted on first edge
        step();
        chk("ldi_valid", ex_valid, 1);
        chk("ldi_op", ex_op, 6);
        chk("ldi_opA", ex_opA, 16'h0000);
        chk("ldi_opB", ex_opB, 16'h00AB);
        chk("ldi_rd", ex_rd, 2);
        chk("ldi_we", ex_we, 1);
        chk("ldi_busy", dut.u_sb.busy_q, 8'h04);

        // ADD r3,r2,r2 stalls on r2; rf returns a stale 0
        if_instr = 16'h1690;
        #1 chk("add_stall_ready", if_ready, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("add_stall_cnt%0d", i), stall_cnt, i);
        end
        chk("add_stall_exv", ex_valid, 0);
        wb_valid = 1'b1;
        wb_addr  = 3'd2;
        wb_data  = 16'h00AB;
        #1 chk("add_wb_ready", if_ready, 1);
        step();
        wb_valid = 1'b0;
        chk("add_op", ex_op, 1);
        chk("add_opA_byp", ex_opA, 16'h00AB);
        chk("add_opB_byp", ex_opB, 16'h00AB);
        chk("add_rd", ex_rd, 3);
        chk("add_cnt_hold", stall_cnt, 3);
        chk("add_busy", dut.u_sb.busy_q, 8'h08);

        // ADDI r1,r1,-1 with r1 = 5
        if_instr = 16'h527F;
        rf_a     = 16'h0005;
        step();
        chk("addi_opA", ex_opA, 16'h0005);
        chk("addi_opB", ex_opB, 16'hFFFF);
        chk("addi_rd", ex_rd, 1);
        chk("addi_busy", dut.u_sb.busy_q, 8'h0A);
        #1 chk("addi2_ready", if_ready, 0);
        step();
        chk("addi2_cnt", stall_cnt, 4);
        chk("addi2_exv", ex_valid, 0);
        wb_valid = 1'b1;
        wb_addr  = 3'd1;
        wb_data  = 16'h0004;
        #1 chk("addi2_wb_ready", if_ready, 1);
        step();
        chk("addi2_opA_byp", ex_opA, 16'h0004);
        chk("addi2_busy_setwins", dut.u_sb.busy_q, 8'h0A);

        // Drain r1 and r3, then park a NOP in ID/EX
        if_valid = 1'b0;
        step();
        wb_addr = 3'd3;
        step();
        chk("drain_busy", dut.u_sb.busy_q, 8'h00);
        wb_valid = 1'b0;
        if_valid = 1'b1;
        if_instr = 16'h0000;
        step();
        chk("nop_exv", ex_valid, 1);
        chk("nop_we", ex_we, 0);

        // Back-pressure: ADD r3,r1,r2 waits for ex_ready
        ex_ready = 1'b0;
        if_instr = 16'h1650;
        rf_a     = 16'h0011;
        rf_b     = 16'h0022;
        #1 chk("bp_ready", if_ready, 0);
        step();
        chk("bp_exv_hold", ex_valid, 1);
        chk("bp_op_hold", ex_op, 0);
        chk("bp_cnt_hold", stall_cnt, 4);
        ex_ready = 1'b1;
        #1 chk("bp_ready_up", if_ready, 1);
        step();
        chk("bp_op", ex_op, 1);
        chk("bp_opA", ex_opA, 16'h0011);
        chk("bp_opB", ex_opB, 16'h0022);
        chk("bp_rd", ex_rd, 3);

        // Undefined opcode
        if_instr = 16'hF000;
        step();
        chk("ill_flag", ex_illegal, 1);
        chk("ill_we", ex_we, 0);
        chk("ill_busy", dut.u_sb.busy_q, 8'h08);

        // LDI r4 while r4 retires: set wins
        if_instr = 16'h6805;
        wb_valid = 1'b1;
        wb_addr  = 3'd4;
        wb_data  = 16'h0099;
        step();
        wb_valid = 1'b0;
        if_valid = 1'b0;
        chk("sw_opB", ex_opB, 16'h0005);
        chk("sw_busy", dut.u_sb.busy_q, 8'h18);

        // Asynchronous reset mid-operation, between edges
        #2 reset = 1'b0;
        #1;
        chk("arst_exv", ex_valid, 0);
        chk("arst_cnt", stall_cnt, 0);
        chk("arst_busy", dut.u_sb.busy_q, 0);
        chk("arst_opB", ex_opB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction decode stage that sits directly upstream of register_file and directly downstream of fetch. It accepts 16-bit instructions over a valid/ready handshake and drives register_file read addresses ra/rb. It resolves operands, including a writeback bypass and immediates, into a one-entry ID/EX pipeline register for execute. A per-register scoreboard stalls fetch on RAW and WAW hazards until writeback releases the register.

Parameters:
WIDTH, 16, datapath and instruction width
ADDR_W, 3, register address width (8 registers)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_valid  in  1  fetch presents an instruction
if_instr  in  WIDTH  instruction: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6, [8:0] imm9
if_ready  out  1  decode accepts if_instr this cycle
rf_ra  out  ADDR_W  register_file read address a; equals if_instr[8:6]
rf_rb  out  ADDR_W  register_file read address b; equals if_instr[5:3]
rf_a  in  WIDTH  register_file combinational read data a
rf_b  in  WIDTH  register_file combinational read data b
wb_valid  in  1  writeback retiring this cycle; same signal drives register_file writeEnable
wb_addr  in  ADDR_W  writeback destination
wb_data  in  WIDTH  writeback data
ex_ready  in  1  execute accepts ID/EX contents
ex_valid  out  1  ID/EX register holds an instruction
ex_op  out  4  opcode
ex_opA  out  WIDTH  resolved operand A
ex_opB  out  WIDTH  resolved operand B
ex_rd  out  ADDR_W  destination register
ex_we  out  1  instruction writes rd
ex_illegal  out  1  opcode was undefined (7..15)
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset, asynchronous and active-low: ex_valid, ex_op, ex_opA, ex_opB, ex_rd, ex_we, ex_illegal, the scoreboard busy[7:0] and stall_cnt all go to 0 immediately. Reset mid-operation discards in-flight state with no partial updates.
- Opcodes:
  - 0 NOP: no sources, we=0.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: sources rs1 and rs2; opA=R[rs1], opB=R[rs2]; we=1.
  - 5 ADDI: source rs1; opA=R[rs1], opB=sign-extended imm6; we=1.
  - 6 LDI: no sources; opA=0, opB=zero-extended imm9; we=1.
  - 7..15: treated as NOP with ex_illegal=1 and we=0.
- Operand bypass: if wb_valid and wb_addr equals a used source, that operand takes wb_data instead of rf_a/rf_b. register_file writes at the same edge, so without the bypass the read would return the stale value.
- Hazard (combinational, evaluated only when if_valid):
  - A used source is busy, or (we=1 and busy[rd]).
  - A busy register whose wb_addr matches with wb_valid this cycle does not count as busy.
- Handshake:
  - slot_free = !ex_valid || ex_ready.
  - if_ready = slot_free && !hazard.
  - Accept on if_valid && if_ready; the ID/EX register loads at that edge, giving 1-cycle latency.
  - If slot_free and nothing is accepted, ex_valid clears.
  - If !slot_free, the ID/EX register holds all of its contents.
- Scoreboard:
  - On accept with we=1, set busy[rd].
  - On wb_valid, clear busy[wb_addr].
  - If both hit the same index in one cycle, set wins.
  - WAW stalling guarantees at most one outstanding write per register.
- stall_cnt increments on each cycle where if_valid && slot_free && hazard, and saturates at all-ones.
- if_instr must be held stable while if_valid && !if_ready; this is a fetch obligation and is checked by an assertion in the bench.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants OP_NOP..OP_LDI;
  - instruction field position constants;
  - a struct for the ID/EX payload (op, opA, opB, rd, we, illegal).
- The natural sub-module is decode_scoreboard: the busy[7:0] vector with set/clear ports, two source hazard query ports and one destination hazard query port.
- Operand muxing and the pipeline register stay in decode_stage.

Test Plan:
- Reset low with if_valid=1 and if_instr=0x64AB; release reset -> all ex_* and stall_cnt are 0 during reset. On the first accepted edge: ex_valid=1, ex_op=6, ex_opA=0, ex_opB=0x00AB, ex_rd=2, ex_we=1, busy[2]=1.
- LDI r2 (0x64AB) followed by ADD r3,r2,r2 (0x1690), with no wb and ex_ready=1 -> ADD stalls: if_ready=0 and stall_cnt counts 1,2,3. Then pulse wb_valid with wb_addr=2 and wb_data=0x00AB -> ADD accepted that cycle with ex_opA=ex_opB=0x00AB, taken from the bypass and not from the stale rf_a.
- rf_a holds 0x0005 for r1; issue ADDI r1,r1,-1 (0x527F) with busy clear -> ex_opA=0x0005, ex_opB=0xFFFF, ex_rd=1, busy[1]=1. A second 0x527F is not accepted until wb of r1.
- ex_ready=0 while ex_valid=1; present ADD r3,r1,r2 (0x1650) with r1 and r2 not busy -> if_ready=0, ex_* unchanged, stall_cnt unchanged. Raise ex_ready -> 0x1650 accepted next edge.
- Issue opcode 0xF (0xF000) -> ex_illegal=1, ex_we=0, and no scoreboard bit set.
- Accept LDI r4 while wb_valid retires r4 in the same cycle -> busy[4] remains 1 (set wins).
